control_fsm: RTL and testbench
==============================

CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 No parameters.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 op  in  7  instruction opcode, taken from the instruction register.
REQ-005 funct3  in  3  instruction funct3 field.
REQ-006 funct7b5  in  1  bit 30 of the instruction.
REQ-007 Zero  in  1  ALU zero flag, valid in the cycle the branch compare is on the ALU.
REQ-008 PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc  out  1 each  datapath enables and address select.
REQ-009 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  out  2 each  datapath mux selects.
REQ-010 ALUControl  out  3  ALU operation: 000 AND, 001 OR, 010 ADD, 011 SUB; 1xx is never driven.
REQ-011 Illegal  out  1  one-cycle pulse for an undecodable instruction.

Function
REQ-012 The block SHALL be a Moore FSM with these states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, BRANCH.
REQ-013 FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALU op ADD, ResultSrc=10, PC update=1; always goes to DECODE.
REQ-014 DECODE: ALUSrcA=01, ALUSrcB=01, ALU op ADD; next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1101111 -> JAL
  - 1100011 -> BRANCH
  - any other op -> FETCH with Illegal=1.
REQ-015 MEMADR: ALUSrcA=10, ALUSrcB=01, ADD; lw goes to MEMREAD, sw goes to MEMWRITE.
REQ-016 MEMREAD: AdrSrc=1, then MEMWB.
REQ-017 MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
REQ-018 MEMWRITE: AdrSrc=1, MemWrite=1, then FETCH.
REQ-019 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALU op decoded from funct3/funct7b5, then ALUWB.
REQ-020 EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALU op decoded from funct3/funct7b5, then ALUWB.
REQ-021 ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
REQ-022 JAL: ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=00, PC update=1, then ALUWB.
REQ-023 BRANCH: ALUSrcA=10, ALUSrcB=00, SUB, ResultSrc=00, branch=1, then FETCH.
REQ-024 PCWrite SHALL equal (PC update) OR (branch AND taken), evaluated combinationally in the same cycle as Zero.
REQ-025 For a branch with funct3=000 (beq), taken SHALL equal Zero.
REQ-026 ALU decode: funct3 000 -> SUB if (op[5] AND funct7b5), else ADD; 110 -> OR; 111 -> AND.
REQ-027 In EXECUTER or EXECUTEI, any other funct3 SHALL drive ALUControl=010, suppress RegWrite in the following ALUWB, and pulse Illegal for one cycle.
REQ-028 ImmSrc SHALL be decoded combinationally from op in every state:
  - 00 for lw and I-type
  - 01 for sw
  - 10 for branch
  - 11 for jal.
REQ-029 Cycle counts from FETCH to the next FETCH: lw 5, sw 4, R 4, I 4, jal 4, branch 3, illegal 2.
REQ-030 Any output not listed for a state SHALL be 0 in that state.

Reset
REQ-031 When reset=1 at a rising edge, the state SHALL become FETCH, regardless of the current state.
REQ-032 While reset=1, PCWrite, IRWrite, MemWrite, RegWrite and Illegal SHALL be forced to 0; all other outputs SHALL hold their FETCH values.
REQ-033 In the first cycle after reset deasserts, the block SHALL perform FETCH; a reset mid-instruction SHALL abandon that instruction with no write.

Configuration
REQ-034 With macro BNE_BRANCH_EN defined, a branch with funct3=001 SHALL be bne, with taken equal to NOT Zero.
REQ-035 Without BNE_BRANCH_EN, a branch with funct3=001, and any branch funct3 other than 000 in either build, SHALL be illegal:
  - leave DECODE to FETCH with Illegal=1
  - PCWrite=0.

Verification
REQ-036 lw (op=0000011) from reset -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in cycle 5 with ResultSrc=01.
REQ-037 R-type sub (funct3=000, funct7b5=1) -> ALUControl=011 in EXECUTER; the same instruction with funct7b5=0 -> 010.
REQ-038 beq with Zero=1 in BRANCH -> PCWrite=1; with Zero=0 -> PCWrite=0; next state FETCH in both cases.
REQ-039 bne (funct3=001) with Zero=0 -> PCWrite=1 when BNE_BRANCH_EN is defined; Illegal=1 in DECODE and PCWrite=0 when it is not.
REQ-040 op=1111111 -> Illegal pulses in DECODE and the next state is FETCH; reset asserted in MEMWRITE -> MemWrite=0 that cycle and state FETCH after the edge.

Source files
------------

// File: rtl/control_fsm.sv
// Multicycle RISC-V main control FSM (lw, sw, R, I, jal, beq).
// Define BNE_BRANCH_EN to also accept bne (branch funct3=001).
module control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       Illegal
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, ALUWB, JAL, BRANCH
    } state_t;

    state_t     state;
    logic       skip_wb;
    logic       alu_legal;
    logic [2:0] alu_dec;
    logic       br_legal;
    logic       taken;
    logic       decode_ok;
    logic       pc_update;
    logic       branch;

    always_comb begin
        alu_legal = 1'b1;
        alu_dec   = ALU_ADD;
        case (funct3)
            3'b000:  alu_dec = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
            3'b110:  alu_dec = ALU_OR;
            3'b111:  alu_dec = ALU_AND;
            default: alu_legal = 1'b0;
        endcase
    end

    always_comb begin
`ifdef BNE_BRANCH_EN
        br_legal = (funct3 == 3'b000) || (funct3 == 3'b001);
        taken    = (funct3 == 3'b001) ? ~Zero : Zero;
`else
        br_legal = (funct3 == 3'b000);
        taken    = Zero;
`endif
    end

    always_comb begin
        case (op)
            OP_LW, OP_SW, OP_R, OP_I, OP_JAL: decode_ok = 1'b1;
            OP_BR:                            decode_ok = br_legal;
            default:                          decode_ok = 1'b0;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BR:   ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // skip_wb carries an undecodable ALU funct3 from EXECUTE* into ALUWB
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            skip_wb <= 1'b0;
        end else begin
            skip_wb <= ((state == EXECUTER) || (state == EXECUTEI)) && !alu_legal;
            case (state)
                FETCH:  state <= DECODE;
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_R:         state <= EXECUTER;
                        OP_I:         state <= EXECUTEI;
                        OP_JAL:       state <= JAL;
                        OP_BR:        state <= br_legal ? BRANCH : FETCH;
                        default:      state <= FETCH;
                    endcase
                end
                MEMADR:   state <= op[5] ? MEMWRITE : MEMREAD;
                MEMREAD:  state <= MEMWB;
                EXECUTER: state <= ALUWB;
                EXECUTEI: state <= ALUWB;
                JAL:      state <= ALUWB;
                default:  state <= FETCH;
            endcase
        end
    end

    always_comb begin
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_AND;
        Illegal    = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        case (state)
            FETCH: begin
                IRWrite = 1'b1; ALUSrcB = 2'b10; ALUControl = ALU_ADD;
                ResultSrc = 2'b10; pc_update = 1'b1;
            end
            DECODE: begin
                ALUSrcA = 2'b01; ALUSrcB = 2'b01; ALUControl = ALU_ADD;
                Illegal = !decode_ok;
            end
            MEMADR: begin
                ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUControl = ALU_ADD;
            end
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01; RegWrite = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1; MemWrite = 1'b1;
            end
            EXECUTER: begin
                ALUSrcA = 2'b10; ALUControl = alu_dec; Illegal = !alu_legal;
            end
            EXECUTEI: begin
                ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUControl = alu_dec;
                Illegal = !alu_legal;
            end
            ALUWB:    RegWrite = !skip_wb;
            JAL: begin
                ALUSrcA = 2'b01; ALUSrcB = 2'b10; ALUControl = ALU_ADD;
                pc_update = 1'b1;
            end
            BRANCH: begin
                ALUSrcA = 2'b10; ALUControl = ALU_SUB; branch = 1'b1;
            end
            default: ;
        endcase
        PCWrite = pc_update | (branch & taken);
        // reset overrides: writes off, selects parked at their FETCH values
        if (reset) begin
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            MemWrite   = 1'b0;
            RegWrite   = 1'b0;
            Illegal    = 1'b0;
            AdrSrc     = 1'b0;
            ResultSrc  = 2'b10;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b10;
            ALUControl = ALU_ADD;
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm; expectations follow BNE_BRANCH_EN when defined.
module tb_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    control_fsm dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .Zero(Zero),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    // {PCWrite,IRWrite,MemWrite,RegWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,Illegal}
    logic [16:0] outs;
    assign outs = {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc,
                   ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal};

    function automatic logic [16:0] V(input logic pcw, input logic irw,
                                      input logic mw, input logic rw,
                                      input logic adr, input logic [1:0] res,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [1:0] imm, input logic [2:0] alu,
                                      input logic ill);
        return {pcw, irw, mw, rw, adr, res, sa, sb, imm, alu, ill};
    endfunction

    task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string tag, input logic [16:0] exp);
        #1;
        check(tag, outs, exp);
        tick();
    endtask

    task automatic start(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic z, input logic [1:0] imm, input string tag);
        op = o; funct3 = f3; funct7b5 = f7; Zero = z;
        cyc({tag, ".fetch"},  V(1,1,0,0,0,2'b10,2'b00,2'b10,imm,3'b010,0));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b1; op = OP_LW; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
        tick();
        cyc("reset.a", V(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b010,0));
        cyc("reset.b", V(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b010,0));
        reset = 1'b0;

        // lw: 5 cycles, write-back only in the last
        start(OP_LW, 3'b010, 0, 0, 2'b00, "lw");
        cyc("lw.decode",  V(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b010,0));
        cyc("lw.memadr",  V(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b010,0));
        cyc("lw.memread", V(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
        cyc("lw.memwb",   V(0,0,0,1,0,2'b01,2'b00,2'b00,2'b00,3'b000,0));

        start(OP_SW, 3'b010, 0, 0, 2'b01, "sw");
        cyc("sw.decode",  V(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b010,0));
        cyc("sw.memadr",  V(0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b010,0));
        cyc("sw.memwr",   V(0,0,1,0,1,2'b00,2'b00,2'b00,2'b01,3'b000,0));

        start(OP_R, 3'b000, 1, 0, 2'b00, "sub");
        cyc("sub.decode", V(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b010,0));
        cyc("sub.exec",   V(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b011,0));
        cyc("sub.wb",     V(0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));

        start(OP_R, 3'b000, 0, 0, 2'b00, "add");
        cyc("add.decode", V(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b010,0));
        cyc("add.exec",   V(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b010,0));
        cyc("add.wb",     V(0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));

        // I-type ignores funct7b5 for funct3=000 (op[5]=0)
        start(OP_I, 3'b000, 1, 0, 2'b00, "addi");
        cyc("addi.decode", V(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b010,0));
        cyc("addi.exec",   V(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b010,0));
        cyc("addi.wb",     V(0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));

        start(OP_I, 3'b110, 0, 0, 2'b00, "ori");
        cyc("ori.decode", V(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b010,0));
        cyc("ori.exec",   V(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b001,0));
        cyc("ori.wb",     V(0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));

        start(OP_R, 3'b111, 0, 0, 2'b00, "and");
        cyc("and.decode", V(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b010,0));
        cyc("and.exec",   V(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b000,0));
        cyc("and.wb",     V(0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));

        // undecodable ALU funct3: Illegal in execute, no write-back
        start(OP_R, 3'b001, 0, 0, 2'b00, "sll");
        cyc("sll.decode", V(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b010,0));
        cyc("sll.exec",   V(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b010,1));
        cyc("sll.wb",     V(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));

        start(OP_JAL, 3'b000, 0, 0, 2'b11, "jal");
        cyc("jal.decode", V(0,0,0,0,0,2'b00,2'b01,2'b01,2'b11,3'b010,0));
        cyc("jal.jal",    V(1,0,0,0,0,2'b00,2'b01,2'b10,2'b11,3'b010,0));
        cyc("jal.wb",     V(0,0,0,1,0,2'b00,2'b00,2'b00,2'b11,3'b000,0));

        // beq: PCWrite follows Zero combinationally inside BRANCH
        start(OP_BR, 3'b000, 0, 1, 2'b10, "beq");
        cyc("beq.decode", V(0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b010,0));
        #1;
        check("beq.taken", outs, V(1,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b011,0));
        Zero = 1'b0;
        cyc("beq.nottaken", V(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b011,0));

        start(OP_BR, 3'b001, 0, 0, 2'b10, "bne");
`ifdef BNE_BRANCH_EN
        cyc("bne.decode", V(0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b010,0));
        #1;
        check("bne.taken", outs, V(1,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b011,0));
        Zero = 1'b1;
        cyc("bne.nottaken", V(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b011,0));
`else
        cyc("bne.decode", V(0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b010,1));
`endif

        // blt is illegal in either build
        start(OP_BR, 3'b100, 0, 0, 2'b10, "blt");
        cyc("blt.decode", V(0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b010,1));

        start(OP_BAD, 3'b000, 0, 0, 2'b00, "bad");
        cyc("bad.decode", V(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b010,1));

        // reset during MEMWRITE suppresses the store and restarts at FETCH
        start(OP_SW, 3'b010, 0, 0, 2'b01, "swrst");
        cyc("swrst.decode", V(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b010,0));
        cyc("swrst.memadr", V(0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b010,0));
        reset = 1'b1;
        cyc("swrst.memwr",  V(0,0,0,0,0,2'b10,2'b00,2'b10,2'b01,3'b010,0));
        reset = 1'b0;
        cyc("swrst.fetch",  V(1,1,0,0,0,2'b10,2'b00,2'b10,2'b01,3'b010,0));
        cyc("swrst.decode2", V(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b010,0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
